// File: rtl/program_loader_if.sv
// Byte-stream and program-memory write signals between a byte source, the loader and program memory.
interface program_loader_if #(
   parameter int unsigned ADDR_WIDTH = 8
);
   logic                  start_i;
   logic [7:0]            rx_data_i;
   logic                  rx_valid_i;
   logic                  rx_ready_o;
   logic                  mem_we_o;
   logic [ADDR_WIDTH-1:0] mem_addr_o;
   logic [31:0]           mem_wdata_o;
   logic                  core_reset_o;
   logic                  busy_o;
   logic                  done_o;
   logic                  error_o;

   // Loader side
   modport slave (
      input  start_i, rx_data_i, rx_valid_i,
      output rx_ready_o, mem_we_o, mem_addr_o, mem_wdata_o,
             core_reset_o, busy_o, done_o, error_o
   );

   // Source/controller side
   modport master (
      output start_i, rx_data_i, rx_valid_i,
      input  rx_ready_o, mem_we_o, mem_addr_o, mem_wdata_o,
             core_reset_o, busy_o, done_o, error_o
   );
endinterface

// File: rtl/program_loader.sv
// Packs a framed byte stream (count, 4*N little-endian data bytes, XOR check) into
// 32-bit program memory writes and releases the core from reset on a clean load.
module program_loader #(
   parameter int unsigned ADDR_WIDTH = 8,
   parameter int unsigned MAX_WORDS  = 64
) (
   input  logic             clk,
   input  logic             reset_ni,
   program_loader_if.slave  bus
);

   typedef enum logic [2:0] {
      IDLE,
      COUNT,
      DATA,
      WRITE,
      CHECK,
      ERROR
   } state_t;

   state_t     state;
   logic [7:0] count;
   logic [7:0] word_cnt;
   logic [7:0] checksum;
   logic [1:0] byte_cnt;
   logic       accept_c;

   assign accept_c = bus.rx_valid_i & bus.rx_ready_o;

   // Frame sequencer; all outputs are registered alongside the state
   always_ff @(posedge clk or negedge reset_ni) begin
      if (!reset_ni) begin
         state            <= IDLE;
         count            <= '0;
         word_cnt         <= '0;
         checksum         <= '0;
         byte_cnt         <= '0;
         bus.rx_ready_o   <= 1'b0;
         bus.mem_we_o     <= 1'b0;
         bus.mem_addr_o   <= '0;
         bus.mem_wdata_o  <= '0;
         bus.core_reset_o <= 1'b1;
         bus.busy_o       <= 1'b0;
         bus.done_o       <= 1'b0;
         bus.error_o      <= 1'b0;
      end else begin
         bus.done_o   <= 1'b0;
         bus.mem_we_o <= 1'b0;
         case (state)
            IDLE, ERROR: begin
               if (bus.start_i) begin
                  state            <= COUNT;
                  bus.rx_ready_o   <= 1'b1;
                  bus.busy_o       <= 1'b1;
                  bus.core_reset_o <= 1'b1;
                  bus.error_o      <= 1'b0;
                  checksum         <= '0;
               end
            end
            COUNT: begin
               if (accept_c) begin
                  if (bus.rx_data_i == 8'd0 || 32'(bus.rx_data_i) > MAX_WORDS) begin
                     state            <= ERROR;
                     bus.rx_ready_o   <= 1'b0;
                     bus.busy_o       <= 1'b0;
                     bus.error_o      <= 1'b1;
                     bus.core_reset_o <= 1'b1;
                  end else begin
                     state          <= DATA;
                     count          <= bus.rx_data_i;
                     checksum       <= bus.rx_data_i;
                     word_cnt       <= '0;
                     byte_cnt       <= '0;
                     bus.mem_addr_o <= '0;
                  end
               end
            end
            DATA: begin
               // Shift right so the first byte of a word ends up in bits [7:0]
               if (accept_c) begin
                  bus.mem_wdata_o <= {bus.rx_data_i, bus.mem_wdata_o[31:8]};
                  checksum        <= checksum ^ bus.rx_data_i;
                  byte_cnt        <= 2'(byte_cnt + 2'd1);
                  if (byte_cnt == 2'd3) begin
                     state          <= WRITE;
                     bus.rx_ready_o <= 1'b0;
                     bus.mem_we_o   <= 1'b1;
                  end
               end
            end
            WRITE: begin
               bus.mem_addr_o <= ADDR_WIDTH'(bus.mem_addr_o + ADDR_WIDTH'(4));
               word_cnt       <= 8'(word_cnt + 8'd1);
               bus.rx_ready_o <= 1'b1;
               state          <= (8'(word_cnt + 8'd1) == count) ? CHECK : DATA;
            end
            CHECK: begin
               if (accept_c) begin
                  bus.rx_ready_o <= 1'b0;
                  bus.busy_o     <= 1'b0;
                  if (bus.rx_data_i == checksum) begin
                     state            <= IDLE;
                     bus.done_o       <= 1'b1;
                     bus.core_reset_o <= 1'b0;
                  end else begin
                     state       <= ERROR;
                     bus.error_o <= 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
